// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and constants.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    EMIT
  } state_t;

  // Indices outside 1..10 never occur in operation; they map to 0 so the
  // lookup stays total for any 4-bit index.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      if (idx == 4'(k)) r = RCON[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/function_g.sv
// AES-128 key-schedule g(): RotWord, SubWord, then Rcon into the top byte.
module function_g
  import aes_pkg::*;
(
  input  word_t      w,
  input  logic [3:0] rnd,
  output word_t      g
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  word_t rot;

  assign rot = {w[23:0], w[31:24]};
  assign g   = {SBOX[rot[31:24]] ^ rcon_of(rnd),
                SBOX[rot[23:16]],
                SBOX[rot[15:8]],
                SBOX[rot[7:0]]};

endmodule

// File: rtl/key_schedule_rev_iter.sv
// Iterative AES-128 round-key generator emitting keys in decryption order (10 -> 0).
//   state | meaning
//   IDLE  | waiting for start; outputs quiet
//   FWD   | walking the schedule forward from round 0 to round 10
//   EMIT  | presenting round key rk_round, stepping back one round per handshake
module key_schedule_rev_iter
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             key_is_last,
  input  logic [127:0]     key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk_data,
  output logic [RND_W-1:0] rk_round,
  output logic             rk_last
);

  generate
    if (NR != AES_NR) begin : g_nr_check
      $error("key_schedule_rev_iter supports only NR == 10 (AES-128)");
    end
  endgenerate

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);
  localparam logic [3:0]       FWD_END  = 4'(NR - 1);

  state_t           state;
  block_t           kq;
  logic [3:0]       cnt;
  logic [RND_W-1:0] rnd;

  word_t w0, w1, w2, w3;
  word_t g_in, g_out;
  logic [3:0] g_idx;
  word_t n0, n1, n2, n3;
  word_t p0, p1, p2, p3;

  assign {w0, w1, w2, w3} = kq;

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // One g() serves both directions: forward uses w3/cnt+1, reverse uses p3/rnd.
  assign g_in  = (state == FWD) ? w3 : p3;
  assign g_idx = (state == FWD) ? (cnt + 4'd1) : rnd[3:0];

  function_g u_g (
    .w   (g_in),
    .rnd (g_idx),
    .g   (g_out)
  );

  assign n0 = w0 ^ g_out;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign p0 = w0 ^ g_out;

  assign rk_data  = kq;
  assign rk_round = rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      kq       <= '0;
      cnt      <= '0;
      rnd      <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            kq   <= key;
            busy <= 1'b1;
            if (key_is_last) begin
              state    <= EMIT;
              rnd      <= LAST_RND;
              rk_valid <= 1'b1;
              rk_last  <= 1'b0;
            end else begin
              state <= FWD;
              cnt   <= '0;
              rnd   <= '0;
            end
          end
        end
        FWD: begin
          kq  <= {n0, n1, n2, n3};
          cnt <= cnt + 4'd1;
          if (cnt == FWD_END) begin
            state    <= EMIT;
            rnd      <= LAST_RND;
            rk_valid <= 1'b1;
            rk_last  <= 1'b0;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (rnd == '0) begin
              state    <= IDLE;
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
            end else begin
              kq      <= {p0, p1, p2, p3};
              rnd     <= rnd - RND_W'(1);
              rk_last <= (rnd == RND_W'(1));
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          rk_valid <= 1'b0;
          rk_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_rev_iter.sv
// Directed bench for the reverse-order AES-128 key schedule.
module tb_key_schedule_rev_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         key_is_last;
  logic [127:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ZK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  key_schedule_rev_iter #(.NR(10), .RND_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_is_last (key_is_last),
    .key         (key),
    .busy        (busy),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_data     (rk_data),
    .rk_round    (rk_round),
    .rk_last     (rk_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  busy,     '0);
    check({tag, "_valid"}, rk_valid, '0);
    check({tag, "_last"},  rk_last,  '0);
    check({tag, "_data"},  rk_data,  '0);
    check({tag, "_round"}, rk_round, '0);
  endtask

  // Pulse start and count cycles until rk_valid; optionally poke a stray start mid-FWD.
  task automatic start_run(input logic [127:0] k, input logic last, input int exp_lat, input bit inject);
    int n;
    @(negedge clk);
    key = k; key_is_last = last; start = 1'b1;
    n = 0;
    while (!rk_valid && n < 40) begin
      @(negedge clk);
      n++;
      start = inject && (n == 4);
      if (start) begin key = '1; key_is_last = 1'b1; end
    end
    start = 1'b0;
    check("latency", 128'(n), 128'(exp_lat));
  endtask

  task automatic collect(input bit stall, input bit inject, input int abort_at, input bit zero_mode);
    int r;
    int guard;
    bit rdy;
    logic [127:0] exp;
    r = 10;
    guard = 0;
    while (r >= 0 && guard < 200) begin
      guard++;
      check($sformatf("valid_r%0d", r), rk_valid, 1);
      check($sformatf("round_r%0d", r), rk_round, 128'(r));
      check($sformatf("last_r%0d", r),  rk_last,  (r == 0) ? 1 : 0);
      if (!zero_mode || r == 10 || r == 0) begin
        exp = zero_mode ? ((r == 10) ? ZK10 : '0) : fips[r];
        check($sformatf("data_r%0d", r), rk_data, exp);
      end
      if (abort_at == r) begin
        rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("post_reset_valid", rk_valid, 0);
          check("post_reset_busy",  busy,     0);
        end
        return;
      end
      rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      rk_ready = rdy;
      start = inject && rdy && (r == 6 || r == 0);
      if (start) begin key = '1; key_is_last = 1'b1; end
      @(negedge clk);
      start = 1'b0;
      rk_ready = 1'b1;
      if (rdy) r--;
    end
    if (guard >= 200) check("collect_timeout", 0, 1);
    check("end_busy",  busy,     0);
    check("end_valid", rk_valid, 0);
    if (inject) begin
      repeat (3) begin
        @(negedge clk);
        check("no_replay_valid", rk_valid, 0);
        check("no_replay_busy",  busy,     0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_is_last = 1'b0; key = '0; rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("idle");

    start_run(fips[0], 1'b0, 11, 1'b0);
    collect(1'b0, 1'b0, -1, 1'b0);

    start_run(fips[10], 1'b1, 1, 1'b0);
    collect(1'b0, 1'b0, -1, 1'b0);

    start_run(fips[0], 1'b0, 11, 1'b0);
    collect(1'b1, 1'b0, -1, 1'b0);

    start_run(fips[0], 1'b0, 11, 1'b1);
    collect(1'b0, 1'b1, -1, 1'b0);

    start_run(fips[0], 1'b0, 11, 1'b0);
    collect(1'b1, 1'b0, 5, 1'b0);
    start_run(fips[0], 1'b0, 11, 1'b0);
    collect(1'b0, 1'b0, -1, 1'b0);

    start_run('0, 1'b0, 11, 1'b0);
    collect(1'b0, 1'b0, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule_rev_iter.md
Name: key_schedule_rev_iter

Overview:
Iterative AES-128 round-key generator that delivers round keys in decryption order: round 10 first, round 0 last. It takes either the cipher key or the round-10 key. When given the cipher key, it first walks the schedule forward to round 10. It then walks the schedule backward one round per accepted handshake. It sits in front of the inverse-cipher datapath, which consumes one round key per inverse round, and replaces the 11-key combinational expansion with a single 128-bit state register.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported; other values are a configuration error.
RND_W, 4, width of the round index output.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle request; sampled only in IDLE.
key_is_last  in  1  qualifies key at start: 0 = key is the cipher key (round 0); 1 = key is the round-10 key.
key  in  128  key word, {w0,w1,w2,w3}, w0 = bits 127:96.
busy  out  1  high in every state except IDLE.
rk_valid  out  1  round key available.
rk_ready  in  1  consumer accepts rk_data when rk_valid & rk_ready.
rk_data  out  128  current round key {w4i..w4i+3}.
rk_round  out  RND_W  round index of rk_data, 10 down to 0.
rk_last  out  1  high with rk_valid when rk_round == 0.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; key register, rk_round and counter clear to 0.
  - busy, rk_valid and rk_last go to 0; rk_data reads 0.
  - Reset mid-operation abandons the sequence; no partial output follows release.
- States: IDLE, FWD, EMIT.
- IDLE:
  - On start, key is loaded into the state register.
  - key_is_last=0: go to FWD with cnt=0.
  - key_is_last=1: go to EMIT with rk_round=10.
- FWD:
  - Each cycle the register advances from round cnt to round cnt+1.
  - Forward step: t = g(w3, cnt+1); n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - After the step that produces round 10 (cnt=9), go to EMIT with rk_round=10. FWD lasts exactly 10 cycles.
- EMIT:
  - rk_valid=1; rk_data = register; rk_round = current round.
  - rk_data and rk_round hold stable while rk_valid & !rk_ready.
  - On handshake with rk_round>0, the register steps back to round r-1 and rk_round decrements. The next key is valid on the following cycle, so throughput is one key per cycle while rk_ready is held high.
  - Reverse step from round r words (a,b,c,d): p3 = d^c; p2 = c^b; p1 = b^a; p0 = a^g(p3, r).
  - On handshake with rk_round==0 (rk_last=1): go to IDLE; rk_valid drops the next cycle.
- g(w, i) is the standard AES-128 round function: RotWord, then SubWord, then XOR with Rcon(i) in the top byte. Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36.
- A single g instance is shared: its input is w3 with index cnt+1 in FWD, and p3 with index rk_round in EMIT.
- start while busy is ignored; no queuing, no error flag.
- start and the final handshake in the same cycle: the handshake completes and start is dropped. The caller must re-assert start in IDLE.
- Latency from start to first rk_valid:
  - key_is_last=0: 11 cycles (start edge, then 10 FWD cycles).
  - key_is_last=1: 1 cycle.
- A full sequence is 11 handshakes. After the last one the unit is idle and accepts a new start.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NR = 10.
  - typedef word_t = logic [31:0].
  - typedef block_t = logic [127:0].
  - Rcon constant array indexed 1..10.
  - State enum {IDLE, FWD, EMIT}.
- One sub-module: the existing function_g (word, round index → 32-bit result), instantiated once with a muxed input.
- The S-box stays inside function_g and is not duplicated.

Test Plan:
1. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, key_is_last=0, start, rk_ready=1 → rk_valid rises after 11 cycles. Keys then arrive one per cycle:
   - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
   - round 9 = ac7766f319fadc2128d12941575c006e
   - round 1 = a0fafe1788542cb123a339392a6c7605
   - round 0 = 2b7e151628aed2a6abf7158809cf4f3c, with rk_last=1
   Then busy falls.
2. key = d014f9a8c9ee2589e13f0cc8b6630ca6, key_is_last=1 → round-10 key one cycle after start. The same 11-key sequence follows, ending with round 0 = 2b7e...4f3c.
3. Run scenario 1 with random rk_ready stalls → rk_data and rk_round hold during stalls. Exactly 11 handshakes occur with rounds 10..0 in order and no skips or duplicates.
4. Pulse start during FWD and during EMIT → no effect: the sequence and values are unchanged, and the second start is not replayed.
5. Assert rst_n low mid-EMIT at round 5 → all outputs go to 0 immediately. After release the unit stays idle (rk_valid=0) until a new start, and a fresh run matches scenario 1.
6. All-zero cipher key, key_is_last=0 → round 10 = b4ef5bcb3e92e21123e951cf6f8f188e. The reverse walk returns round 0 = 0.
